// File: rtl/levenshtein_pattern_loader_if.sv
// Wishbone master bus used by the Levenshtein pattern loader.
// Signal names follow the master's point of view (_o driven by master, _i by slave).
interface levenshtein_pattern_loader_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [ADDR_WIDTH-1:0] wbm_adr_o;
    logic [7:0]            wbm_dat_o;
    logic [7:0]            wbm_dat_i;
    logic                  wbm_ack_i;
    logic                  wbm_err_i;
    logic                  wbm_rty_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/levenshtein_pattern_loader.sv
// Builds the 256 x 16-bit pattern-match vector table for a search word in Wishbone
// memory: clears all 512 bytes, then read-modify-writes one bit per character.
module levenshtein_pattern_loader #(
    parameter int MASTER_ADDR_WIDTH = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic        chr_valid_i,
    output logic        chr_ready_o,
    input  logic [7:0]  chr_data_i,
    input  logic        chr_last_i,
    output logic [4:0]  word_length_o,
    output logic [15:0] mask_o,
    output logic [15:0] initial_vp_o,
    levenshtein_pattern_loader_if.master wbm
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_CHAR, S_READ, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t      r_state, w_next;
    logic        r_cyc;
    logic        r_err;
    logic [8:0]  r_clr_addr;
    logic [4:0]  r_pos;          // reaches 16 only after a 16th non-last character
    logic [7:0]  r_char;
    logic        r_last;
    logic [7:0]  r_rdata;
    logic [4:0]  r_word_length;
    logic [15:0] r_mask;
    logic [15:0] r_initial_vp;

    logic        w_bus_state;
    logic        w_ack;
    logic        w_fail;
    logic        w_chr_fire;
    logic        w_chr_bad;
    logic        w_writing;
    logic [8:0]  w_rmw_addr;
    logic [8:0]  w_byte_addr;
    logic [7:0]  w_wdata;
    logic [15:0] w_mask;

    assign w_bus_state = (r_state == S_CLEAR) || (r_state == S_READ) || (r_state == S_WRITE);
    assign w_ack       = r_cyc && wbm.wbm_ack_i;
    assign w_fail      = r_cyc && (wbm.wbm_err_i || wbm.wbm_rty_i);
    assign w_chr_fire  = chr_valid_i && (r_state == S_WAIT_CHAR);
    assign w_chr_bad   = (chr_data_i == 8'hFE) || (chr_data_i == 8'hFF) || r_pos[4];
    assign w_writing   = r_cyc && ((r_state == S_CLEAR) || (r_state == S_WRITE));

    // Positions 0..7 live in the low byte {c,1}, positions 8..15 in the high byte {c,0}.
    assign w_rmw_addr  = {r_char, (r_pos < 5'd8)};
    assign w_byte_addr = (r_state == S_CLEAR) ? r_clr_addr : w_rmw_addr;
    assign w_wdata     = (r_state == S_WRITE) ? (r_rdata | (8'd1 << r_pos[2:0])) : 8'h00;
    assign w_mask      = 16'd1 << r_pos[3:0];

    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_cyc;
    assign wbm.wbm_we_o  = w_writing;
    assign wbm.wbm_adr_o = r_cyc ? {{(MASTER_ADDR_WIDTH-9){1'b0}}, w_byte_addr} : '0;
    assign wbm.wbm_dat_o = w_writing ? w_wdata : 8'h00;

    assign err_o         = r_err;
    assign word_length_o = r_word_length;
    assign mask_o        = r_mask;
    assign initial_vp_o  = r_initial_vp;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_next      = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        chr_ready_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                busy_o = 1'b1;
                if (w_fail)                               w_next = S_ERROR;
                else if (w_ack && (r_clr_addr == 9'd511)) w_next = S_WAIT_CHAR;
            end
            S_WAIT_CHAR: begin
                busy_o      = 1'b1;
                chr_ready_o = 1'b1;
                if (w_chr_fire) w_next = w_chr_bad ? S_ERROR : S_READ;
            end
            S_READ: begin
                busy_o = 1'b1;
                if (w_fail)     w_next = S_ERROR;
                else if (w_ack) w_next = S_WRITE;
            end
            S_WRITE: begin
                busy_o = 1'b1;
                if (w_fail)     w_next = S_ERROR;
                else if (w_ack) w_next = r_last ? S_DONE : S_WAIT_CHAR;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc         <= 1'b0;
            r_err         <= 1'b0;
            r_clr_addr    <= '0;
            r_pos         <= '0;
            r_char        <= '0;
            r_last        <= 1'b0;
            r_rdata       <= '0;
            r_word_length <= '0;
            r_mask        <= '0;
            r_initial_vp  <= '0;
        end else begin
            // Cycle strobe rises the cycle after a bus phase starts and falls after any response.
            r_cyc <= w_bus_state && (w_next == r_state || !r_cyc) && !(w_ack || w_fail);

            if (r_state == S_IDLE && start_i) begin
                r_err      <= 1'b0;
                r_clr_addr <= '0;
                r_pos      <= '0;
            end else if (w_next == S_ERROR) begin
                r_err <= 1'b1;
            end

            if (r_state == S_CLEAR && w_ack) r_clr_addr <= r_clr_addr + 9'd1;

            if (w_chr_fire) begin
                r_char <= chr_data_i;
                r_last <= chr_last_i;
            end

            if (r_state == S_READ && w_ack && !w_fail) r_rdata <= wbm.wbm_dat_i;

            if (r_state == S_WRITE && w_ack && !w_fail) begin
                if (r_last) begin
                    r_word_length <= r_pos + 5'd1;
                    r_mask        <= w_mask;
                    r_initial_vp  <= w_mask | (w_mask - 16'd1);
                end else begin
                    r_pos <= r_pos + 5'd1;
                end
            end
        end
    end

endmodule

// File: doc/levenshtein_pattern_loader.md
LEVENSHTEIN_PATTERN_LOADER -- requirements
Module: levenshtein_pattern_loader

Interface
REQ-001 SHALL have parameter MASTER_ADDR_WIDTH, default 24, Wishbone master address width.
REQ-002 SHALL have port clk_i  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports start_i in 1 (begin load); busy_o out 1; done_o out 1 (one-cycle pulse); err_o out 1 (sticky until next start_i).
REQ-005 SHALL have ports chr_valid_i in 1, chr_ready_o out 1, chr_data_i in 8, chr_last_i in 1 (search-word byte stream; last marks final character).
REQ-006 SHALL have ports word_length_o out 5, mask_o out 16, initial_vp_o out 16 (search parameters for the distance controller).
REQ-007 SHALL have Wishbone master ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_adr_o out MASTER_ADDR_WIDTH; wbm_dat_o out 8; wbm_dat_i in 8; wbm_ack_i, wbm_err_i, wbm_rty_i in 1.

Function
REQ-008 SHALL build the 256-entry, 16-bit pattern-match vector table: vector for byte c at addresses {c,0} (bits 15:8) and {c,1} (bits 7:0), zero-extended to MASTER_ADDR_WIDTH with MSB 0.
REQ-009 SHALL set bit i of vector[c] for every character c at word position i (position 0 = first character, bit 0).
REQ-010 SHALL implement states IDLE, CLEAR, WAIT_CHAR, READ, WRITE, DONE, ERROR.
REQ-011 IDLE: start_i high -> CLEAR, clear err_o, position counter 0, byte address 0; start_i in any other state SHALL be ignored.
REQ-012 CLEAR: write 0x00 to byte addresses 0..511 in ascending order, one write per transaction; after ack of address 511 -> WAIT_CHAR.
REQ-013 WAIT_CHAR: chr_ready_o=1 only here; on chr_valid_i&&chr_ready_o latch char, last flag and position -> READ.
REQ-014 READ: read byte address {c, pos<8}; on ack latch wbm_dat_i -> WRITE.
REQ-015 WRITE: write latched byte OR (1 << pos[2:0]) to same address; on ack: if last -> DONE, else pos+1 -> WAIT_CHAR.
REQ-016 Transaction timing: cyc=stb asserted from the cycle after entering the bus phase through the ack cycle inclusive; deasserted the next cycle; at least one idle cycle between transactions; wbm_we_o=1 only for CLEAR/WRITE transactions; wbm_dat_o=0x00 when not writing.
REQ-017 DONE (one cycle): done_o=1, word_length_o=pos+1, mask_o=1<<pos, initial_vp_o=(1<<(pos+1))-1 -> IDLE; outputs hold until next DONE or reset.
REQ-018 chr_data_i of 0xFE or 0xFF (dictionary markers), or a 17th character (pos=15 accepted without last) SHALL go to ERROR without any bus access for that character.
REQ-019 wbm_err_i or wbm_rty_i during an active transaction SHALL drop cyc/stb next cycle and go to ERROR.
REQ-020 ERROR: err_o=1, busy_o=0, -> IDLE next cycle; parameter outputs unchanged.
REQ-021 busy_o=1 in CLEAR, WAIT_CHAR, READ, WRITE, DONE.
REQ-022 Repeated characters SHALL accumulate bits (read-modify-write, never overwrite).

Reset
REQ-023 rst_i SHALL force IDLE with busy_o, done_o, err_o, chr_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0, wbm_adr_o=0, wbm_dat_o=0x00, word_length_o=0, mask_o=0, initial_vp_o=0.
REQ-024 Reset mid-transaction SHALL drop wbm_cyc_o at the next edge; no further bus activity until start_i.

Verification
REQ-025 start, word "ab" (0x61, 0x62 last) -> 512 zero writes, then addr 0xC3 written 0x01, addr 0xC5 written 0x02; word_length_o=2, mask_o=0x0002, initial_vp_o=0x0003, done_o one cycle.
REQ-026 word "aa" -> addr 0xC3 final 0x03; word_length_o=2.
REQ-027 9-char word "xxxxxxxxy" -> addr 0xF0 ('x' hi) 0x00, 0xF1 0xFF, 0xF2 ('y' hi) 0x01; mask_o=0x0100, initial_vp_o=0x01FF.
REQ-028 17 chars, none last -> err_o=1 after 17th handshake, no bus cycle for it, done_o never pulses.
REQ-029 wbm_err_i at CLEAR address 5 -> cyc low next cycle, err_o=1, busy_o=0; later start_i restarts clear at address 0 and clears err_o.
REQ-030 rst_i asserted during READ with cyc high -> cyc low next edge, all outputs at reset values.
